// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 receive front end.
//   - receiver FSM state type
//   - frame constants and the make/break/extended prefixes seen by the downstream filter
//   - default timing parameters (50 MHz system clock)
package ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_e;

  localparam int         PS2_DATA_BITS    = 8;
  localparam logic [7:0] PS2_BREAK_PFX    = 8'hF0;
  localparam logic [7:0] PS2_EXT_PFX      = 8'hE0;

  localparam int         PS2_FILT_LEN_DEF = 8;
  localparam int         PS2_TIMEOUT_DEF  = 100000;  // 2 ms at 50 MHz

  // PS/2 uses odd parity over data + parity bit.
  function automatic logic ps2_odd_ones(input logic [8:0] v);
    return ^v;
  endfunction
endpackage

// File: rtl/ps2_frame_rx_if.sv
// ps2_frame_rx_if: PS/2 line inputs and keycode outputs of the receiver.
//   kclk, kdata : raw PS/2 lines (keyboard -> host)
//   keycode     : [15:8] previous byte, [7:0] latest byte
//   oflag       : one-cycle pulse, keycode updated
//   ferr        : one-cycle pulse, framing/parity/timeout error
// master = the receiver, slave = the keyboard side plus keycode consumer.
interface ps2_frame_rx_if;
  logic        kclk;
  logic        kdata;
  logic [15:0] keycode;
  logic        oflag;
  logic        ferr;

  modport master (input kclk, kdata, output keycode, oflag, ferr);
  modport slave  (output kclk, kdata, input keycode, oflag, ferr);
endinterface

// File: rtl/ps2_sync_filter.sv
// ps2_sync_filter: 2-FF synchroniser followed by a run-length deglitch filter.
//   clk, rst : system clock, async active-high reset
//   din      : raw asynchronous line
//   dout     : filtered level (resets to 1, the idle level of PS/2 lines)
//   fall     : one-cycle strobe when dout goes 1 -> 0
// dout only moves after FILT_LEN consecutive synchronised samples that differ
// from it; any shorter excursion resets the run counter.
module ps2_sync_filter #(
  parameter int FILT_LEN = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic fall
);
  localparam int CW = $clog2(FILT_LEN + 1);

  logic          s1_q, s2_q;
  logic          filt_q, filt_d;
  logic          fall_q, fall_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    filt_d = filt_q;
    fall_d = 1'b0;
    cnt_d  = '0;
    if (s2_q != filt_q) begin
      if (cnt_q == CW'(FILT_LEN - 1)) begin
        filt_d = s2_q;
        fall_d = filt_q & ~s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      filt_q <= 1'b1;
      fall_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      s1_q   <= din;
      s2_q   <= s1_q;
      filt_q <= filt_d;
      fall_q <= fall_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = filt_q;
  assign fall = fall_q;
endmodule

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: PS/2 device-to-host frame receiver.
//   clk, rst : 50 MHz system clock, async active-high reset
//   bus      : ps2_frame_rx_if.master (kclk/kdata in, keycode/oflag/ferr out)
// Deglitches both lines, deserialises 11-bit frames on filtered kclk falling
// edges and shifts each good byte into a 16-bit history.
// Optional macro PS2_PARITY_CHECK_EN: when defined, frames with even parity
// over data+parity are rejected; otherwise only the stop bit is checked.
module ps2_frame_rx
  import ps2_pkg::*;
#(
  parameter int FILT_LEN    = PS2_FILT_LEN_DEF,
  parameter int TIMEOUT_CYC = PS2_TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            rst,
  ps2_frame_rx_if.master  bus
);
  localparam int TW = $clog2(TIMEOUT_CYC);

  logic kclk_f, kclk_fall, kdata_f;

  ps2_sync_filter #(.FILT_LEN(FILT_LEN)) u_kclk (
    .clk(clk), .rst(rst), .din(bus.kclk), .dout(kclk_f), .fall(kclk_fall)
  );
  ps2_sync_filter #(.FILT_LEN(FILT_LEN)) u_kdata (
    .clk(clk), .rst(rst), .din(bus.kdata), .dout(kdata_f), .fall()
  );

  ps2_state_e        state_q, state_d;
  logic [2:0]        bcnt_q, bcnt_d;
  logic [7:0]        sh_q, sh_d;
  logic [TW-1:0]     to_q, to_d;
  logic [15:0]       kc_q, kc_d;
  logic              oflag_q, oflag_d;
  logic              ferr_q, ferr_d;
  logic              frame_ok;
`ifdef PS2_PARITY_CHECK_EN
  logic              par_q, par_d;
`endif

  always_comb begin
    state_d  = state_q;
    bcnt_d   = bcnt_q;
    sh_d     = sh_q;
    kc_d     = kc_q;
    to_d     = '0;
    oflag_d  = 1'b0;
    ferr_d   = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d    = par_q;
    frame_ok = kdata_f & ps2_odd_ones({sh_q, par_q});
`else
    frame_ok = kdata_f;
`endif
    // A falling edge always wins over an expiring timeout on the same cycle.
    if (kclk_fall) begin
      unique case (state_q)
        IDLE: if (!kdata_f) begin
          state_d = DATA;
          bcnt_d  = '0;
        end
        DATA: begin
          sh_d = {kdata_f, sh_q[7:1]};  // LSB arrives first
          if (bcnt_q == 3'(PS2_DATA_BITS - 1)) state_d = PARITY;
          else bcnt_d = bcnt_q + 1'b1;
        end
        PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_d = kdata_f;
`endif
          state_d = STOP;
        end
        STOP: begin
          if (frame_ok) begin
            kc_d    = {kc_q[7:0], sh_q};
            oflag_d = 1'b1;
          end else begin
            ferr_d  = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (to_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d = IDLE;
        ferr_d  = 1'b1;
      end else begin
        to_d = to_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      sh_q    <= '0;
      to_q    <= '0;
      kc_q    <= '0;
      oflag_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      sh_q    <= sh_d;
      to_q    <= to_d;
      kc_q    <= kc_d;
      oflag_q <= oflag_d;
      ferr_q  <= ferr_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.keycode = kc_q;
  assign bus.oflag   = oflag_q;
  assign bus.ferr    = ferr_q;
endmodule

// File: tb/tb_ps2_frame_rx.sv
// tb_ps2_frame_rx: directed + randomized PS/2 frames against a byte-level
// reference model (expected keycode history and per-frame flag counts).
// PS/2 clock and timeout are scaled down so the run stays short.
module tb_ps2_frame_rx;
  localparam int FILT  = 8;
  localparam int TOUT  = 2000;
  localparam int HP    = 40;    // PS/2 half period in system cycles

  logic clk = 1'b0;
  logic rst = 1'b1;
  ps2_frame_rx_if bus ();

  ps2_frame_rx #(.FILT_LEN(FILT), .TIMEOUT_CYC(TOUT)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int oflag_tot = 0;
  int ferr_tot  = 0;
  logic [15:0] kc_m = 16'h0000;

  always @(negedge clk) begin
    if (bus.oflag) oflag_tot++;
    if (bus.ferr)  ferr_tot++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Shift out n bits of a frame, LSB (start bit) first; optional 3-cycle
  // low glitch on kclk during the high phase of bit glitch_at.
  task automatic send_bits(input logic [10:0] bits, input int n, input int glitch_at);
    for (int i = 0; i < n; i++) begin
      bus.kdata = bits[i];
      if (i == glitch_at) begin
        cyc(HP / 2);
        bus.kclk = 1'b0;
        cyc(3);
        bus.kclk = 1'b1;
        cyc(HP - HP / 2 - 3);
      end else begin
        cyc(HP);
      end
      bus.kclk = 1'b0;
      cyc(HP);
      bus.kclk = 1'b1;
    end
    bus.kdata = 1'b1;
  endtask

  function automatic logic good_par(input logic [7:0] b);
    return ~^b;
  endfunction

  // Send a full frame and compare flags/keycode with the model.
  task automatic frame(input string tag, input logic [7:0] b, input logic par,
                       input logic stop, input int glitch_at);
    int of0, fe0;
    logic ok;
    of0 = oflag_tot;
    fe0 = ferr_tot;
`ifdef PS2_PARITY_CHECK_EN
    ok = stop && (^{b, par} == 1'b1);
`else
    ok = stop;
`endif
    if (ok) kc_m = {kc_m[7:0], b};
    send_bits({stop, par, b, 1'b0}, 11, glitch_at);
    cyc(60);
    chk({tag, ".oflag"}, oflag_tot - of0, ok ? 1 : 0);
    chk({tag, ".ferr"},  ferr_tot - fe0,  ok ? 0 : 1);
    chk({tag, ".kc"},    bus.keycode, kc_m);
  endtask

  initial begin
    int of0, fe0;
    logic [7:0] b;
    logic p, s;
    bus.kclk  = 1'b1;
    bus.kdata = 1'b1;
    cyc(5);
    @(negedge clk);
    chk("rst.kc", bus.keycode, 16'h0000);
    chk("rst.oflag", bus.oflag, 1'b0);
    chk("rst.ferr", bus.ferr, 1'b0);
    rst = 1'b0;
    cyc(30);

    frame("f1c", 8'h1C, good_par(8'h1C), 1'b1, -1);
    frame("ff0", 8'hF0, good_par(8'hF0), 1'b1, -1);
    frame("f1c2", 8'h1C, good_par(8'h1C), 1'b1, -1);
    frame("f5a_badpar", 8'h5A, 1'b0, 1'b1, -1);
    frame("glitch", 8'h1C, good_par(8'h1C), 1'b1, 5);
    frame("badstop", 8'h33, good_par(8'h33), 1'b0, -1);

    // Partial frame: start + 4 data bits, then idle-high well past timeout.
    of0 = oflag_tot;
    fe0 = ferr_tot;
    send_bits({3'b111, 8'h5A, 1'b0}, 5, -1);
    cyc(TOUT + 500);
    chk("tout.ferr", ferr_tot - fe0, 1);
    chk("tout.oflag", oflag_tot - of0, 0);
    chk("tout.kc", bus.keycode, kc_m);
    frame("after_tout", 8'h5A, good_par(8'h5A), 1'b1, -1);

    // Reset mid-frame: outputs clear asynchronously, frame lost.
    send_bits({3'b111, 8'h77, 1'b0}, 4, -1);
    cyc(20);
    #3 rst = 1'b1;
    #1;
    chk("midrst.kc", bus.keycode, 16'h0000);
    chk("midrst.oflag", bus.oflag, 1'b0);
    kc_m = 16'h0000;
    cyc(5);
    rst = 1'b0;
    cyc(30);
    frame("f29", 8'h29, good_par(8'h29), 1'b1, -1);
    chk("f29.exact", bus.keycode, 16'h0029);

    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom_range(0, 255));
      p = ($urandom_range(0, 3) == 0) ? ~good_par(b) : good_par(b);
      s = ($urandom_range(0, 7) != 0);
      frame($sformatf("rnd%0d", i), b, p, s,
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 10)) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
